// File: rtl/mem_read_streamer_pkg.sv
// Shared constants and sizing helpers for the memory read streamer slice.
package mem_read_streamer_pkg;

    localparam int MAX_READ_LATENCY = 3;

    // The skid FIFO must absorb every read in flight plus the one being issued.
    function automatic int buf_depth(input int read_latency);
        return read_latency + 1;
    endfunction

    // Width that holds inflight + buffered words without wrapping.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth);
    endfunction

endpackage

// File: rtl/mem_read_streamer_if.sv
// Port-B read bus plus the outgoing valid/ready stream of the read streamer.
interface mem_read_streamer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output rd_addr, rd_en, out_valid, out_data,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_addr, rd_en, out_valid, out_data,
        output rd_data, out_ready
    );
endinterface

// File: rtl/mem_read_streamer_skid_fifo.sv
// Synchronous first-word-fall-through FIFO used to absorb read data under backpressure.
module stream_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     store [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : store[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; empty gates head, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_read_streamer.sv
// Reads every word the port-A writer has produced, in order, and streams it out with
// credit-based flow control that covers the fixed memory read latency.
module mem_read_streamer
    import mem_read_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] backlog,
    mem_read_streamer_if.master   bus
);
    localparam int BUF_DEPTH      = buf_depth(READ_LATENCY);
    localparam int OCC_WIDTH      = occ_width(BUF_DEPTH);
    localparam int FIFO_CNT_WIDTH = $clog2(BUF_DEPTH + 1);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("mem_read_streamer: READ_LATENCY must be 1..3");
    end

    logic [ADDR_WIDTH-1:0]     issued;
    logic [ADDR_WIDTH-1:0]     next_addr;
    logic [READ_LATENCY-1:0]   inflight;
    logic [OCC_WIDTH-1:0]      inflight_cnt;
    logic [OCC_WIDTH-1:0]      occupancy;
    logic [FIFO_CNT_WIDTH-1:0] fifo_count;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      issue;
    logic                      push;
    logic                      pop;

    // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + OCC_WIDTH'(inflight[i]);
        end
    end

    // A pop this cycle frees its slot in time for the word we would issue now.
    assign pop       = bus.out_valid && bus.out_ready;
    assign occupancy = inflight_cnt + OCC_WIDTH'(fifo_count) - OCC_WIDTH'(pop);
    assign issue     = !reset && enable && (wr_addr != issued)
                       && (occupancy < OCC_WIDTH'(BUF_DEPTH));

    assign next_addr   = issued + ADDR_WIDTH'(1);
    assign bus.rd_en   = issue;
    assign bus.rd_addr = issue ? next_addr : issued;
    assign backlog     = wr_addr - issued;
    assign push        = inflight[READ_LATENCY-1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued   <= '0;
            inflight <= '0;
        end else begin
            if (issue) issued <= next_addr;
            inflight[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                inflight[i] <= inflight[i-1];
            end
        end
    end

    stream_skid_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.rd_data),
        .pop       (pop),
        .head      (bus.out_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.out_valid = !fifo_empty;

    // A push into a full FIFO without a pop means the credit check is broken.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !pop));

    a_out_stable : assert property (@(posedge clk) disable iff (reset)
        bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data));

endmodule

// File: tb/tb_mem_read_streamer.sv
// Directed bench: instance A (16-bit, latency 1) and instance B (4-bit pointers, latency 3).
module tb_mem_read_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        reset_a, enable_a;
    logic [15:0] wr_a, backlog_a;
    mem_read_streamer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_a ();
    mem_read_streamer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(1)) u_a (
        .clk     (clk),
        .reset   (reset_a),
        .enable  (enable_a),
        .wr_addr (wr_a),
        .backlog (backlog_a),
        .bus     (bus_a)
    );

    // Memory A holds 0xA0 + address; one cycle of read latency.
    always @(posedge clk)
        bus_a.rd_data <= bus_a.rd_en ? (32'hA0 + 32'(bus_a.rd_addr)) : 32'hDEAD_BEEF;

    logic       reset_b, enable_b;
    logic [3:0] wr_b, backlog_b;
    mem_read_streamer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_b ();
    mem_read_streamer #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(3)) u_b (
        .clk     (clk),
        .reset   (reset_b),
        .enable  (enable_b),
        .wr_addr (wr_b),
        .backlog (backlog_b),
        .bus     (bus_b)
    );

    logic [31:0] mem_b  [16];
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_b[0] <= bus_b.rd_en ? mem_b[bus_b.rd_addr] : 32'hDEAD_BEEF;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_b.rd_data = pipe_b[2];

    logic [31:0] exp_q[$];
    logic [31:0] seq_b  = 32'hB000_0001;
    int          got_b  = 0;
    int          sent_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_a_seq();
        reset_a = 1'b1; enable_a = 1'b1; wr_a = '0; bus_a.out_ready = 1'b1;
        cyc(); cyc();
        reset_a = 1'b0;
    endtask

    task automatic reset_b_seq();
        reset_b = 1'b1; enable_b = 1'b1; wr_b = '0; bus_b.out_ready = 1'b1;
        cyc(); cyc();
        reset_b = 1'b0;
        exp_q.delete();
    endtask

    // One cycle of B: writer adds wr_inc words, then every accepted word is scoreboarded.
    task automatic b_cycle(input logic rdy, input int wr_inc);
        cyc();
        for (int j = 0; j < wr_inc; j++) begin
            wr_b = wr_b + 4'd1;
            mem_b[wr_b] = seq_b;
            exp_q.push_back(seq_b);
            seq_b = seq_b + 32'd1;
            sent_b++;
        end
        bus_b.out_ready = rdy;
        settle();
        if (bus_b.out_valid && bus_b.out_ready) begin
            got_b++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL b_extra_word observed=0x%0h expected=none", bus_b.out_data);
            end else begin
                check("b_stream_word", bus_b.out_data, exp_q.pop_front());
            end
        end
    endtask

    task automatic drain_b();
        for (int k = 0; k < 60 && (exp_q.size() > 0 || bus_b.out_valid); k++) b_cycle(1'b1, 0);
        check("b_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses, valid_cnt, bad;
        logic [31:0] data_seen, late_w;

        reset_b = 1'b1; enable_b = 1'b1; wr_b = '0; bus_b.out_ready = 1'b1;

        // Reset values; backlog must follow wr_addr even during reset.
        reset_a = 1'b1; enable_a = 1'b1; wr_a = 16'h0003; bus_a.out_ready = 1'b1;
        cyc(); cyc(); settle();
        check("rst_rd_en",     32'(bus_a.rd_en),     32'd0);
        check("rst_rd_addr",   32'(bus_a.rd_addr),   32'd0);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_data",  bus_a.out_data,       32'd0);
        check("rst_backlog",   32'(backlog_a),       32'd3);
        cyc();
        wr_a = '0; reset_a = 1'b0;

        // Five writes, out_ready high: issues 1..5, data back-to-back 2 cycles later.
        for (int i = 1; i <= 9; i++) begin
            cyc();
            if (i <= 5) wr_a = 16'(i);
            settle();
            check($sformatf("t1_rd_en_c%0d", i),   32'(bus_a.rd_en),     (i <= 5) ? 32'd1 : 32'd0);
            check($sformatf("t1_rd_addr_c%0d", i), 32'(bus_a.rd_addr),   (i <= 5) ? 32'(i) : 32'd5);
            check($sformatf("t1_valid_c%0d", i),   32'(bus_a.out_valid), (i >= 3 && i <= 7) ? 32'd1 : 32'd0);
            if (i >= 3 && i <= 7)
                check($sformatf("t1_data_c%0d", i), bus_a.out_data, 32'hA0 + 32'(i - 2));
        end
        check("t1_backlog_end", 32'(backlog_a), 32'd0);

        // Backlog 8 with out_ready low for 10 cycles: two issues, head held at 0xA1.
        reset_a_seq();
        bus_a.out_ready = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) wr_a = 16'd8;
            settle();
            if (bus_a.rd_en) pulses++;
            if (c >= 3) begin
                check($sformatf("t2_hold_valid_c%0d", c), 32'(bus_a.out_valid), 32'd1);
                check($sformatf("t2_hold_data_c%0d", c),  bus_a.out_data,       32'hA1);
            end
        end
        check("t2_rd_en_pulses", 32'(pulses), 32'd2);
        check("t2_backlog_held", 32'(backlog_a), 32'd6);
        cyc();
        bus_a.out_ready = 1'b1;
        settle();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_drain_valid_%0d", k), 32'(bus_a.out_valid), 32'd1);
            check($sformatf("t2_drain_data_%0d", k),  bus_a.out_data,       32'hA1 + 32'(k));
            cyc(); settle();
        end
        check("t2_empty_after", 32'(bus_a.out_valid), 32'd0);
        check("t2_backlog_end", 32'(backlog_a),       32'd0);

        // Enable dropped the cycle after one issue with backlog 4.
        reset_a_seq();
        cyc();
        wr_a = 16'd4;
        settle();
        check("t4_first_rd_en",   32'(bus_a.rd_en),   32'd1);
        check("t4_first_rd_addr", 32'(bus_a.rd_addr), 32'd1);
        pulses = 0; valid_cnt = 0; data_seen = '0;
        for (int c = 2; c <= 7; c++) begin
            cyc();
            if (c == 2) enable_a = 1'b0;
            settle();
            if (bus_a.rd_en) pulses++;
            if (bus_a.out_valid) begin
                valid_cnt++;
                data_seen = bus_a.out_data;
            end
            check($sformatf("t4_backlog_c%0d", c), 32'(backlog_a), 32'd3);
        end
        check("t4_no_more_rd_en", 32'(pulses),    32'd0);
        check("t4_delivered_cnt", 32'(valid_cnt), 32'd1);
        check("t4_delivered_val", data_seen,      32'hA1);
        enable_a = 1'b1;

        // Pointer wrap on 4-bit instance: issued = 0xE, writer jumps to 0x1.
        reset_b_seq();
        for (int k = 0; k < 14; k++) b_cycle(1'b1, 1);
        drain_b();
        check("t3_pre_backlog", 32'(backlog_b),     32'd0);
        check("t3_pre_issued",  32'(bus_b.rd_addr), 32'hE);
        b_cycle(1'b1, 3);
        check("t3_rd_en_0",   32'(bus_b.rd_en),   32'd1);
        check("t3_rd_addr_0", 32'(bus_b.rd_addr), 32'hF);
        b_cycle(1'b1, 0);
        check("t3_rd_en_1",   32'(bus_b.rd_en),   32'd1);
        check("t3_rd_addr_1", 32'(bus_b.rd_addr), 32'h0);
        b_cycle(1'b1, 0);
        check("t3_rd_en_2",   32'(bus_b.rd_en),   32'd1);
        check("t3_rd_addr_2", 32'(bus_b.rd_addr), 32'h1);
        b_cycle(1'b1, 0);
        check("t3_rd_en_done",   32'(bus_b.rd_en), 32'd0);
        check("t3_backlog_done", 32'(backlog_b),   32'd0);
        drain_b();

        // Reset with two words buffered and one in flight.
        reset_b_seq();
        b_cycle(1'b0, 2);
        b_cycle(1'b0, 0);
        b_cycle(1'b0, 0);
        b_cycle(1'b0, 1);
        b_cycle(1'b0, 0);
        b_cycle(1'b0, 0);
        check("t5_pre_valid", 32'(bus_b.out_valid), 32'd1);
        check("t5_pre_data",  bus_b.out_data,       exp_q[0]);
        late_w = exp_q[2];
        reset_b = 1'b1;
        wr_b = '0;
        cyc();
        reset_b = 1'b0;
        settle();
        check("t5_valid_after_reset", 32'(bus_b.out_valid), 32'd0);
        valid_cnt = 0; bad = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(); settle();
            if (bus_b.out_valid) valid_cnt++;
            if (bus_b.out_data === late_w) bad++;
        end
        check("t5_no_valid_later", 32'(valid_cnt), 32'd0);
        check("t5_late_data_seen", 32'(bad),       32'd0);
        exp_q.delete();

        // Continuous writes with random out_ready on the latency-3 instance.
        reset_b_seq();
        got_b = 0; sent_b = 0;
        for (int n = 0; n < 400; n++)
            b_cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, (backlog_b < 4'd13) ? 1 : 0);
        drain_b();
        check("t6_word_count", 32'(got_b), 32'(sent_b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
